// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - Moore serial pattern transmitter, MSB-first, with repeat and inter-repeat gap
//
// Loads a WIDTH-bit pattern on an accepted start and shifts it out MSB-first
// on x, repeating it repeat_n times with GAP idle cycles between repetitions.
// The pattern and repeat count are captured at acceptance, so input changes
// while busy have no effect.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous reset, active-low
//   start     transmission request, only looked at in IDLE
//   pattern   WIDTH-bit pattern, captured on the accepting edge
//   repeat_n  repetition count, captured with pattern; 0 means no-op
//   x         serial data bit (0 when not shifting)
//   x_valid   high while x carries a pattern bit
//   busy      high from the accepting edge until the return to IDLE
//   done      one-cycle pulse after the final bit

module seq_pattern_tx #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
   // With GAP=0 the GAP state is unreachable; the clamp only keeps the constant legal.
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
   localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_SHIFT = 4'b0010,
      S_GAP   = 4'b0100,
      S_DONE  = 4'b1000
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic [WIDTH-1:0] pat_q;
   logic [WIDTH-1:0] pat_nxt;
   logic [CNT_W-1:0] rep;
   logic [CNT_W-1:0] rep_nxt;
   logic [BIT_W-1:0] bitcnt;
   logic [BIT_W-1:0] bitcnt_nxt;
   logic [GAP_W-1:0] gapcnt;
   logic [GAP_W-1:0] gapcnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         shreg  <= '0;
         pat_q  <= '0;
         rep    <= '0;
         bitcnt <= '0;
         gapcnt <= '0;
      end else begin
         state  <= state_nxt;
         shreg  <= shreg_nxt;
         pat_q  <= pat_nxt;
         rep    <= rep_nxt;
         bitcnt <= bitcnt_nxt;
         gapcnt <= gapcnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      shreg_nxt  = shreg;
      pat_nxt    = pat_q;
      rep_nxt    = rep;
      bitcnt_nxt = bitcnt;
      gapcnt_nxt = gapcnt;

      case (state)
         S_IDLE: begin
            if (start && (repeat_n != '0)) begin
               shreg_nxt  = pattern;
               pat_nxt    = pattern;
               rep_nxt    = repeat_n;
               bitcnt_nxt = '0;
               state_nxt  = S_SHIFT;
            end
         end

         S_SHIFT: begin
            shreg_nxt  = {shreg[WIDTH-2:0], 1'b0};
            bitcnt_nxt = bitcnt + BIT_ONE;
            if (bitcnt == BIT_LAST) begin
               // Last bit of this repetition is on the line this cycle.
               bitcnt_nxt = '0;
               if (rep == REP_ONE) begin
                  state_nxt = S_DONE;
               end else if (GAP == 0) begin
                  // Back-to-back: reload without a bubble cycle.
                  shreg_nxt = pat_q;
                  rep_nxt   = rep - REP_ONE;
               end else begin
                  gapcnt_nxt = '0;
                  rep_nxt    = rep - REP_ONE;
                  state_nxt  = S_GAP;
               end
            end
         end

         S_GAP: begin
            gapcnt_nxt = gapcnt + GAP_ONE;
            if (gapcnt == GAP_LAST) begin
               shreg_nxt  = pat_q;
               bitcnt_nxt = '0;
               state_nxt  = S_SHIFT;
            end
         end

         S_DONE: begin
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Moore outputs: decoded from state and registers only, so the async
   // reset forces them all low immediately.
   assign x_valid = (state == S_SHIFT);
   assign x       = (state == S_SHIFT) ? shreg[WIDTH-1] : 1'b0;
   assign busy    = (state == S_SHIFT) || (state == S_GAP) || (state == S_DONE);
   assign done    = (state == S_DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed self-checking bench for seq_pattern_tx

module tb_seq_pattern_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start0;
   logic       start2;
   logic [3:0] pattern;
   logic [3:0] repeat_n;
   logic       x0, v0, b0, d0;
   logic       x2, v2, b2, d2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_pattern_tx #(.WIDTH(4), .CNT_W(4), .GAP(0)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start0),
      .pattern  (pattern),
      .repeat_n (repeat_n),
      .x        (x0),
      .x_valid  (v0),
      .busy     (b0),
      .done     (d0)
   );

   seq_pattern_tx #(.WIDTH(4), .CNT_W(4), .GAP(2)) u_gap (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start2),
      .pattern  (pattern),
      .repeat_n (repeat_n),
      .x        (x2),
      .x_valid  (v2),
      .busy     (b2),
      .done     (d2)
   );

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulses start for one cycle, then records ncyc cycles of outputs; the
   // first recorded cycle ends up in the highest used bit. During cycles
   // inj_lo..inj_hi a competing start with pattern 0000 is driven.
   task automatic run_seq(input bit use_gap, input logic [3:0] pat, input logic [3:0] rep,
                          input int ncyc, input int inj_lo, input int inj_hi,
                          output logic [127:0] xs, output logic [127:0] vs,
                          output logic [127:0] bs, output logic [127:0] ds);
      xs = '0; vs = '0; bs = '0; ds = '0;
      pattern  = pat;
      repeat_n = rep;
      start0   = !use_gap;
      start2   = use_gap;
      @(posedge clk); #1;
      start0 = 1'b0;
      start2 = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         xs = {xs[126:0], use_gap ? x2 : x0};
         vs = {vs[126:0], use_gap ? v2 : v0};
         bs = {bs[126:0], use_gap ? b2 : b0};
         ds = {ds[126:0], use_gap ? d2 : d0};
         if (c >= inj_lo && c <= inj_hi) begin
            start0   = !use_gap;
            start2   = use_gap;
            pattern  = 4'b0000;
            repeat_n = 4'd3;
         end else begin
            start0 = 1'b0;
            start2 = 1'b0;
         end
         @(posedge clk); #1;
      end
      start0 = 1'b0;
      start2 = 1'b0;
   endtask

   initial begin
      logic [127:0] xs, vs, bs, ds;
      logic [127:0] fl;
      logic [3:0]   sh;
      int           cnt;

      rst_n    = 1'b0;
      start0   = 1'b0;
      start2   = 1'b0;
      pattern  = 4'b0000;
      repeat_n = 4'd0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_dut", {x0, v0, b0, d0}, 4'b0000);
      check_val("reset_gap", {x2, v2, b2, d2}, 4'b0000);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single shot 1101
      run_seq(1'b0, 4'b1101, 4'd1, 6, 0, -1, xs, vs, bs, ds);
      check_val("single_x",    xs, 6'b110100);
      check_val("single_vld",  vs, 6'b111100);
      check_val("single_busy", bs, 6'b111110);
      check_val("single_done", ds, 6'b000010);

      // Back-to-back x3
      run_seq(1'b0, 4'b1101, 4'd3, 14, 0, -1, xs, vs, bs, ds);
      check_val("b2b_x",    xs, 14'b11011101110100);
      check_val("b2b_vld",  vs, 14'b11111111111100);
      check_val("b2b_busy", bs, 14'b11111111111110);
      check_val("b2b_done", ds, 14'b00000000000010);
      sh = 4'b0000;
      fl = '0;
      for (int c = 1; c <= 14; c++) begin
         sh = {sh[2:0], xs[14-c]};
         fl = {fl[126:0], vs[14-c] && (sh == 4'b1101)};
      end
      check_val("b2b_detect", fl, 14'b00010001000100);

      // Gapped x2 with GAP=2
      run_seq(1'b1, 4'b1101, 4'd2, 12, 0, -1, xs, vs, bs, ds);
      check_val("gap_x",    xs, 12'b110100110100);
      check_val("gap_vld",  vs, 12'b111100111100);
      check_val("gap_busy", bs, 12'b111111111110);
      check_val("gap_done", ds, 12'b000000000010);

      // start with repeat_n=0 is a no-op
      run_seq(1'b0, 4'b1101, 4'd0, 4, 0, -1, xs, vs, bs, ds);
      check_val("zero_busy", bs, 4'b0000);
      check_val("zero_done", ds, 4'b0000);

      // start + pattern 0000 during a run (through DONE) is ignored
      run_seq(1'b0, 4'b1101, 4'd1, 8, 2, 5, xs, vs, bs, ds);
      check_val("inj_x",    xs, 8'b11010000);
      check_val("inj_vld",  vs, 8'b11110000);
      check_val("inj_busy", bs, 8'b11111000);
      check_val("inj_done", ds, 8'b00001000);

      // Async reset during bit 2 of the first repetition
      pattern  = 4'b1101;
      repeat_n = 4'd3;
      start0   = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      @(posedge clk); #1;
      check_val("rst_prerun", {x0, v0, b0, d0}, 4'b1110);
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_async", {x0, v0, b0, d0}, 4'b0000);
      @(posedge clk); #1;
      check_val("rst_held", {x0, v0, b0, d0}, 4'b0000);
      #3 rst_n = 1'b1;
      bs = '0;
      ds = '0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         bs = {bs[126:0], b0};
         ds = {ds[126:0], d0};
      end
      check_val("rst_idle_busy", bs, 4'b0000);
      check_val("rst_idle_done", ds, 4'b0000);
      run_seq(1'b0, 4'b1011, 4'd1, 6, 0, -1, xs, vs, bs, ds);
      check_val("post_rst_x",    xs, 6'b101100);
      check_val("post_rst_vld",  vs, 6'b111100);
      check_val("post_rst_done", ds, 6'b000010);

      // Max repeat count 15
      run_seq(1'b0, 4'b1101, 4'd15, 62, 0, -1, xs, vs, bs, ds);
      cnt = $countones(vs);
      check_val("max_vld_count", 128'(cnt), 128'd60);
      check_val("max_vld_shape", vs, {{60{1'b1}}, 2'b00});
      check_val("max_x", xs[61:2], {15{4'b1101}});
      check_val("max_done", ds, 62'h2);
      cnt = $countones(bs);
      check_val("max_busy_count", 128'(cnt), 128'd61);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Moore-style serial pattern transmitter. Loads a parallel bit pattern and shifts it out MSB-first on a one-bit serial line, optionally repeated a programmed number of times.
- Produces the serial stimulus stream consumed by the team's serial sequence detectors, for example the 1101 Moore detector.
- Sits between a control/test sequencer and any single-bit serial receiver.

Parameters:
- WIDTH, 4, pattern length in bits (≥2).
- CNT_W, 4, width of the repeat counter.
- GAP, 0, idle cycles inserted between repetitions (0 = back-to-back).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request to begin a transmission; sampled only in IDLE.
- pattern  input  WIDTH  pattern to send, captured on the accepting edge.
- repeat_n  input  CNT_W  number of repetitions, captured with pattern; 0 = no-op.
- x  output  1  serial data bit, MSB of pattern first.
- x_valid  output  1  high while x carries a pattern bit.
- busy  output  1  high from the accepting edge until return to IDLE.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Reset and polarity: one clock; reset is asynchronous and active-low. rst_n=0 forces the state to IDLE and clears the shift register, bit counter and repeat counter. x=0, x_valid=0, busy=0 and done=0 are held while rst_n=0.
- State encoding: one-hot, four states: IDLE, SHIFT, GAP, DONE. The state register is async-reset. Next-state logic is purely combinational with a default arm → IDLE.
- Output rules (Moore, decoded from state and registers only):
  - x_valid=1 iff SHIFT.
  - x = shreg[WIDTH-1] in SHIFT, else 0.
  - busy=1 in SHIFT, GAP and DONE.
  - done=1 iff DONE.
- IDLE:
  - On an edge with start=1 and repeat_n≠0: shreg←pattern, rep←repeat_n, bitcnt←0, go to SHIFT.
  - start=1 with repeat_n=0 is ignored: stay IDLE, no done.
- SHIFT:
  - Each edge: shreg shifts left one bit (0 filled), bitcnt++.
  - When bitcnt=WIDTH-1, branch on the remaining repetitions:
    - rep=1 → DONE.
    - rep>1 and GAP=0 → reload shreg←captured pattern copy, bitcnt←0, rep--, stay in SHIFT (no bubble).
    - rep>1 and GAP>0 → go to GAP, gapcnt←0, rep--.
- GAP:
  - x=0, x_valid=0 for exactly GAP cycles.
  - Then reload shreg from the captured copy, bitcnt←0, go to SHIFT.
- DONE: lasts exactly one cycle, then IDLE.
- Captured values: the pattern copy and rep are held internally. Changes on pattern or repeat_n while busy have no effect.
- start while busy (including DONE) is ignored and is not queued. A new start is accepted no earlier than the first IDLE cycle.
- Latency:
  - The first bit is visible in the cycle immediately after the accepting edge.
  - Total busy cycles = repeat_n·WIDTH + (repeat_n−1)·GAP + 1.
- Counter widths:
  - bitcnt is clog2(WIDTH) bits and wraps only via explicit reload.
  - rep is CNT_W bits. The maximum repeat_n = 2^CNT_W−1 transmits fully with no overflow.
- Mid-operation reset: rst_n low at any point aborts immediately with all outputs 0 and no done pulse. After rst_n rises, the block stays IDLE until a fresh start.

Test Plan:
- Single shot: WIDTH=4, GAP=0, pattern=4'b1101, repeat_n=1, start pulsed 1 cycle.
  - Required: x=1,1,0,1 on 4 consecutive cycles with x_valid=1.
  - Required: done=1 in cycle 5, busy high for 5 cycles, then IDLE.
- Back-to-back repeat: pattern=1101, repeat_n=3, GAP=0.
  - Required: x = 110111011101 over 12 cycles, x_valid continuously 1, done in cycle 13.
  - Required: a chained 1101 detector flags on cycles 4, 8 and 12.
- Gapped repeat: GAP=2, pattern=1101, repeat_n=2.
  - Required: x_valid pattern 1111 00 1111, x=0 during the gap, done in cycle 11.
- Ignored requests: start with repeat_n=0 → busy stays 0 and no done.
  - Also: start=1 plus pattern=4'b0000 asserted during an active run → the stream is unchanged and no second run follows.
- Async reset mid-run: drop rst_n between clock edges during bit 2 of the first repetition.
  - Required: x, x_valid, busy and done go to 0 immediately, with no done pulse.
  - Required: after release, a new start with pattern=1011 sends 1,0,1,1.
- Max repeat: CNT_W=4, repeat_n=15, GAP=0 → exactly 60 valid bits, then a single done pulse.
